// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio stream controller
package audio_pkg;

   localparam int FRAME_W       = 48;
   localparam int CLK_PER_FRAME = 2500;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      RUN     = 2'd2,
      DRAIN   = 2'd3
   } state_e;

   // States in which sources may be granted and frames written to the FIFO.
   function automatic logic is_writing_state(input logic [1:0] s);
      return (s == PREFILL) || (s == RUN);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with toggling last-grant pointer
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // r_last_grant = 1 means src1 was last, so src0 takes the next tie.
   logic r_last_grant;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
      end else if (advance) begin
         r_last_grant <= ~r_last_grant;
      end
   end

endmodule

// File: rtl/audio_stream_ctrl.sv
// rtl/audio_stream_ctrl.sv - two-source audio frame arbiter feeding an I2S FIFO; optional AUDIO_STREAM_CTRL_MUTE_EN
module audio_stream_ctrl
   import audio_pkg::*;
#(
   parameter int PREFILL_FRAMES = 4,
   parameter int DRAIN_CYCLES   = 8 * CLK_PER_FRAME
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [FRAME_W-1:0] src0_frame,
   input  logic               src0_valid,
   output logic               src0_ready,
   input  logic [FRAME_W-1:0] src1_frame,
   input  logic               src1_valid,
   output logic               src1_ready,
   output logic [FRAME_W-1:0] i2s_frame,
   output logic               i2s_write,
   input  logic               i2s_full,
   output logic               i2s_enable,
   output logic [1:0]         state,
   output logic [15:0]        frames_written
`ifdef AUDIO_STREAM_CTRL_MUTE_EN
   ,
   input  logic               mute
`endif
);

   localparam int         DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_PREFILL = PREFILL;
   localparam logic [1:0] S_RUN     = RUN;
   localparam logic [1:0] S_DRAIN   = DRAIN;

   logic [1:0]         r_state;
   logic [3:0]         r_pref_cnt;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [15:0]        r_frames;

   logic               w_active;
   logic [1:0]         w_req;
   logic [1:0]         w_grant;
   logic               w_write;
   logic [FRAME_W-1:0] w_frame;

   // Requests are masked at the source so a grant always implies a write.
   assign w_active = is_writing_state(r_state);
   assign w_req    = {src1_valid, src0_valid} & {2{w_active & ~i2s_full}};
   assign w_write  = |w_grant;
   assign w_frame  = w_grant[1] ? src1_frame : src0_frame;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (w_req),
      .advance (w_write),
      .grant   (w_grant)
   );

   assign src0_ready     = w_grant[0];
   assign src1_ready     = w_grant[1];
   assign i2s_write      = w_write;
   assign i2s_enable     = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign state          = r_state;
   assign frames_written = r_frames;

`ifdef AUDIO_STREAM_CTRL_MUTE_EN
   assign i2s_frame = mute ? '0 : w_frame;
`else
   assign i2s_frame = w_frame;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pref_cnt  <= '0;
         r_drain_cnt <= '0;
         r_frames    <= '0;
      end else begin
         if (w_write) begin
            r_frames <= r_frames + 16'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  r_state    <= S_PREFILL;
                  r_pref_cnt <= '0;
               end
            end
            S_PREFILL: begin
               if (stop) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
               end else if (i2s_full) begin
                  r_state <= S_RUN;
               end else if (w_write) begin
                  r_pref_cnt <= r_pref_cnt + 4'd1;
                  if (r_pref_cnt == 4'(PREFILL_FRAMES - 1)) begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (stop) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb/tb_audio_stream_ctrl.sv - randomized scoreboard bench for audio_stream_ctrl
module tb_audio_stream_ctrl;

   localparam int P_PREFILL = 4;
   localparam int P_DRAIN   = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic [47:0] src0_frame;
   logic        src0_valid;
   logic        src0_ready;
   logic [47:0] src1_frame;
   logic        src1_valid;
   logic        src1_ready;
   logic [47:0] i2s_frame;
   logic        i2s_write;
   logic        i2s_full;
   logic        i2s_enable;
   logic [1:0]  state;
   logic [15:0] frames_written;
`ifdef AUDIO_STREAM_CTRL_MUTE_EN
   logic        mute;
`endif

   audio_stream_ctrl #(
      .PREFILL_FRAMES (P_PREFILL),
      .DRAIN_CYCLES   (P_DRAIN)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .src0_frame     (src0_frame),
      .src0_valid     (src0_valid),
      .src0_ready     (src0_ready),
      .src1_frame     (src1_frame),
      .src1_valid     (src1_valid),
      .src1_ready     (src1_ready),
      .i2s_frame      (i2s_frame),
      .i2s_write      (i2s_write),
      .i2s_full       (i2s_full),
      .i2s_enable     (i2s_enable),
      .state          (state),
      .frames_written (frames_written)
`ifdef AUDIO_STREAM_CTRL_MUTE_EN
      ,
      .mute           (mute)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      bit          r0;
      bit          r1;
      logic [47:0] fr;
      logic [1:0]  st;
      bit          en;
      logic [15:0] fw;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   pf_writes = 0;
   int   drain_en_cycles = 0;

   // Reference model: spec-level state, counters and round-robin pointer.
   int          m_state = 0;
   int          m_last  = 1;
   int          m_pref  = 0;
   int          m_drain = 0;
   logic [15:0] m_fw    = 16'd0;
   bit          m_known = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit st, input bit sp, input bit v0, input bit v1,
                       input bit full, input logic [47:0] f0, input logic [47:0] f1, input bit mu);
      exp_t e;
      int   g;
      bit   mu_eff;
      @(posedge clk);
      #1;
      reset      = rst;
      start      = st;
      stop       = sp;
      src0_valid = v0;
      src1_valid = v1;
      i2s_full   = full;
      src0_frame = f0;
      src1_frame = f1;
`ifdef AUDIO_STREAM_CTRL_MUTE_EN
      mute   = mu;
      mu_eff = mu;
`else
      mu_eff = 1'b0;
      if (mu) mu_eff = 1'b0;
`endif
      g = -1;
      if ((m_state == 1 || m_state == 2) && !full) begin
         if (v0 && v1)  g = 1 - m_last;
         else if (v0)   g = 0;
         else if (v1)   g = 1;
      end
      if (m_known) begin
         e.wr = (g >= 0);
         e.r0 = (g == 0);
         e.r1 = (g == 1);
         e.fr = mu_eff ? 48'h0 : ((g == 1) ? f1 : f0);
         e.st = 2'(m_state);
         e.en = (m_state >= 2);
         e.fw = m_fw;
         q.push_back(e);
      end
      if (rst) begin
         m_state = 0; m_last = 1; m_pref = 0; m_drain = 0; m_fw = 16'd0;
      end else begin
         if (g >= 0) begin
            m_fw   = m_fw + 16'd1;
            m_last = 1 - m_last;
         end
         case (m_state)
            0: if (st && !sp) begin m_state = 1; m_pref = 0; end
            1: begin
               if (sp) begin m_state = 3; m_drain = P_DRAIN - 1; end
               else if (full) m_state = 2;
               else if (g >= 0) begin
                  m_pref++;
                  if (m_pref == P_PREFILL) m_state = 2;
               end
            end
            2: if (sp) begin m_state = 3; m_drain = P_DRAIN - 1; end
            default: begin
               if (m_drain == 0) m_state = 0;
               else m_drain--;
            end
         endcase
      end
      m_known = 1'b1;
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom), 32'($urandom)};
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("i2s_write", 64'(i2s_write), 64'(e.wr));
            chk("src0_ready", 64'(src0_ready), 64'(e.r0));
            chk("src1_ready", 64'(src1_ready), 64'(e.r1));
            chk("state", 64'(state), 64'(e.st));
            chk("i2s_enable", 64'(i2s_enable), 64'(e.en));
            chk("frames_written", 64'(frames_written), 64'(e.fw));
            if (e.wr) chk("i2s_frame", 64'(i2s_frame), 64'(e.fr));
         end
         if (i2s_write && state == 2'd1) pf_writes++;
         if (state == 2'd3 && i2s_enable) drain_en_cycles++;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      src0_valid = 1'b0; src1_valid = 1'b0; i2s_full = 1'b0;
      src0_frame = '0; src1_frame = '0;
`ifdef AUDIO_STREAM_CTRL_MUTE_EN
      mute = 1'b0;
`endif
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, rnd48(), rnd48(), 0);
      step(0, 0, 0, 1, 1, 0, rnd48(), rnd48(), 0);

      // Prefill with src0 only: exactly PREFILL_FRAMES writes before RUN.
      pf_writes = 0;
      step(0, 1, 0, 1, 0, 0, rnd48(), rnd48(), 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, rnd48(), rnd48(), 0);
      @(negedge clk); #1;
      chk("prefill_write_count", 64'(pf_writes), 64'(P_PREFILL));
      chk("run_after_prefill", 64'(state), 64'd2);

      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, rnd48(), rnd48(), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, rnd48(), rnd48(), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, rnd48(), rnd48(), 0);
      step(0, 0, 0, 1, 0, 0, 48'hABCDEF123456, rnd48(), 1);

      // Stop in RUN: drain holds enable for DRAIN_CYCLES, no grants.
      step(0, 0, 1, 0, 0, 0, rnd48(), rnd48(), 0);
      drain_en_cycles = 0;
      for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 1, 0, rnd48(), rnd48(), 0);
      @(negedge clk); #1;
      chk("drain_enable_cycles", 64'(drain_en_cycles), 64'(P_DRAIN));
      chk("idle_after_drain", 64'(state), 64'd0);
      chk("enable_after_drain", 64'(i2s_enable), 64'd0);

      // Full during prefill after two writes, then reset mid-drain.
      step(0, 1, 0, 1, 0, 0, rnd48(), rnd48(), 0);
      step(0, 0, 0, 1, 0, 0, rnd48(), rnd48(), 0);
      step(0, 0, 0, 1, 0, 0, rnd48(), rnd48(), 0);
      step(0, 0, 0, 1, 0, 1, rnd48(), rnd48(), 0);
      step(0, 0, 0, 1, 0, 0, rnd48(), rnd48(), 0);
      @(negedge clk); #1;
      chk("run_after_prefill_full", 64'(state), 64'd2);
      step(0, 0, 1, 0, 0, 0, rnd48(), rnd48(), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, rnd48(), rnd48(), 0);
      step(1, 0, 0, 0, 0, 0, rnd48(), rnd48(), 0);
      step(0, 0, 0, 0, 0, 0, rnd48(), rnd48(), 0);
      @(negedge clk); #1;
      chk("idle_after_reset_in_drain", 64'(state), 64'd0);
      chk("enable_after_reset_in_drain", 64'(i2s_enable), 64'd0);

      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), rnd48(), rnd48(), 1'($urandom));
      end
      step(0, 0, 0, 0, 0, 0, rnd48(), rnd48(), 0);
      @(negedge clk); #1;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
